// File: rtl/spi_cmd_sched_pkg.sv
// spi_sched_pkg: shared widths, FSM states and the queued command record for spi_cmd_sched
package spi_sched_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 20;
    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, RESP} sched_state_t;
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } spi_cmd_t;
endpackage

// File: rtl/spi_cmd_sched_fifo.sv
// sched_fifo: synchronous command FIFO of DEPTH spi_cmd_t entries
// Ports: clk/rst (sync, active-high), i_push/i_din write side, i_pop/o_dout read side
// (o_dout shows the head), o_full/o_empty flags, o_level occupancy 0..DEPTH.
module sched_fifo import spi_sched_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  spi_cmd_t                 i_din,
    input  logic                     i_pop,
    output spi_cmd_t                 o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    spi_cmd_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic w_push;
    logic w_pop;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_level == LW'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_dout  = r_mem[r_rd_ptr];
    // pointers wrap naturally modulo DEPTH; r_level tells full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end
endmodule

// File: rtl/spi_cmd_sched.sv
// spi_cmd_sched: queues host register commands and issues them one at a time to top_spi
// Ports: clk/rst (sync, active-high); cmd_* host valid/ready command port;
// rsp_* one-cycle read response; spi_* drive/observe top_spi; busy, level status.
// Optional macro SPI_SCHED_TIMEOUT_EN: reads give up after RD_TIMEOUT WAIT cycles with rsp_err=1.
module spi_cmd_sched import spi_sched_pkg::*; #(
    parameter int DEPTH      = 8,
    parameter int WR_WAIT    = 2048,
    parameter int RD_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]      cmd_wdata,
    output logic                   rsp_valid,
    output logic [ADDR_W-1:0]      rsp_addr,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   spi_start,
    output logic                   spi_rw,
    output logic [ADDR_W-1:0]      spi_addr,
    output logic [DATA_W-1:0]      spi_wrdata,
    input  logic                   spi_rd_ok,
    input  logic [DATA_W-1:0]      spi_rddata,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int CNT_MAX = WR_WAIT > RD_TIMEOUT ? WR_WAIT : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    sched_state_t r_state;
    sched_state_t w_next;
    spi_cmd_t w_din;
    spi_cmd_t w_head;
    spi_cmd_t r_hold;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr_done;
    logic w_timeout;
    logic [CNT_W-1:0] r_cnt;
    logic r_start;
    logic r_rsp_valid;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [DATA_W-1:0] r_rsp_data;
    assign w_din = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
    sched_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );
    assign cmd_ready  = !w_full;
    assign busy       = r_state != IDLE || !w_empty;
    assign spi_start  = r_start;
    assign spi_rw     = r_hold.rw;
    assign spi_addr   = r_hold.addr;
    assign spi_wrdata = r_hold.wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_data   = r_rsp_data;
    // r_cnt is 0 in the first WAIT cycle, so the last write WAIT cycle is WR_WAIT-1
    assign w_wr_done = r_cnt == CNT_W'(WR_WAIT - 1);
`ifdef SPI_SCHED_TIMEOUT_EN
    logic r_rsp_err;
    assign w_timeout = r_cnt == CNT_W'(RD_TIMEOUT - 1);
    assign rsp_err   = r_rsp_err;
    // reaching RESP without rd_ok can only mean the timeout fired; rd_ok wins a tie
    always_ff @(posedge clk) begin
        if (rst) r_rsp_err <= 1'b0;
        else if (w_next == RESP) r_rsp_err <= !spi_rd_ok;
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                w_pop  = !w_empty;
                w_next = w_empty ? IDLE : SETUP;
            end
            SETUP: w_next = START;
            START: w_next = WAIT;
            WAIT: begin
                if (!r_hold.rw) w_next = w_wr_done ? IDLE : WAIT;
                else w_next = (spi_rd_ok || w_timeout) ? RESP : WAIT;
            end
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // outputs are registered off the next state so each lines up with its state cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_start     <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_pop) r_hold <= w_head;
            r_start     <= w_next == START;
            r_cnt       <= r_state == WAIT ? r_cnt + 1'b1 : '0;
            r_rsp_valid <= w_next == RESP;
            if (w_next == RESP) begin
                r_rsp_addr <= r_hold.addr;
                r_rsp_data <= spi_rd_ok ? spi_rddata : '0;
            end
        end
    end
endmodule
